// File: rtl/fixed_divide_seq.sv
// Sequential signed Q-format divider: c = trunc((a << fractional_size) / b), one quotient bit per cycle.
// Define FIXED_DIVIDE_SAT_EN to clamp overflowing results; otherwise the low W bits wrap.
module fixed_divide_seq #(
    parameter int fractional_size = 12,
    parameter int operand_size    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [operand_size-1:0] a,
    input  logic [operand_size-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [operand_size-1:0] c,
    output logic                    div_by_zero,
    output logic                    overflow
);
    localparam int W  = operand_size;
    localparam int F  = fractional_size;
    localparam int N  = W + F;
    localparam int CW = $clog2(N + 1);

    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic [N-1:0] MIN_MAG = N'(1) << (W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   dq_reg;
    logic [W-1:0]   rem_reg;
    logic [W-1:0]   div_reg;
    logic           sign_reg;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   c_reg;
    logic           dbz_reg;
    logic           ovf_reg;

    logic [W-1:0]   a_mag, b_mag;
    logic           b_zero;
    logic           last_step;
    logic [W:0]     rem_shift, diff;
    logic           q_bit;
    logic [W-1:0]   rem_step;
    logic [N-1:0]   dq_step;
    logic [N-1:0]   q_neg;
    logic           q_hi_nz;
    logic           ovf_result;
    logic [W-1:0]   wrap_result;
    logic [W-1:0]   c_result;

    assign a_mag     = a[W-1] ? (~a + W'(1)) : a;
    assign b_mag     = b[W-1] ? (~b + W'(1)) : b;
    assign b_zero    = (b == '0);
    assign last_step = (cnt_reg == CW'(N - 1));

    // dq_reg holds the unconsumed dividend bits on the left and the quotient bits built so far on the right.
    assign rem_shift = {rem_reg, dq_reg[N-1]};
    assign diff      = rem_shift - {1'b0, div_reg};
    assign q_bit     = ~diff[W];
    assign rem_step  = q_bit ? diff[W-1:0] : rem_shift[W-1:0];
    assign dq_step   = {dq_reg[N-2:0], q_bit};

    // The final quotient magnitude is dq_step on the last CALC cycle.
    assign q_neg       = ~dq_step + N'(1);
    assign q_hi_nz     = |dq_step[N-1:W-1];
    assign ovf_result  = sign_reg ? (q_hi_nz && (dq_step != MIN_MAG)) : q_hi_nz;
    assign wrap_result = sign_reg ? q_neg[W-1:0] : dq_step[W-1:0];

`ifdef FIXED_DIVIDE_SAT_EN
    assign c_result = ovf_result ? (sign_reg ? MIN_VAL : MAX_VAL) : wrap_result;
`else
    assign c_result = wrap_result;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = b_zero ? DONE : CALC;
            CALC: if (last_step) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dq_reg   <= '0;
            rem_reg  <= '0;
            div_reg  <= '0;
            sign_reg <= 1'b0;
            cnt_reg  <= '0;
            c_reg    <= '0;
            dbz_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg <= a[W-1] ^ b[W-1];
                        div_reg  <= b_mag;
                        dq_reg   <= {a_mag, {F{1'b0}}};
                        rem_reg  <= '0;
                        cnt_reg  <= '0;
                        ovf_reg  <= 1'b0;
                        dbz_reg  <= b_zero;
                        if (b_zero) begin
                            c_reg <= a[W-1] ? MIN_VAL : MAX_VAL;
                        end
                    end
                end
                CALC: begin
                    dq_reg  <= dq_step;
                    rem_reg <= rem_step;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_step) begin
                        c_reg   <= c_result;
                        ovf_reg <= ovf_result;
                        dbz_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign c           = c_reg;
    assign div_by_zero = dbz_reg;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_fixed_divide_seq.sv
// Bench for fixed_divide_seq: directed and random divisions checked against an integer-arithmetic model.
module tb_fixed_divide_seq;
    localparam int W = 32;
    localparam int F = 12;
    localparam int N = W + F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  c;
    logic          div_by_zero;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    fixed_divide_seq #(.fractional_size(F), .operand_size(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer division of the scaled dividend, truncating toward zero.
    function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                  output logic [W-1:0] ec, output logic ez, output logic eo);
        longint sa, sb, q;
        sa = longint'($signed(ta));
        sb = longint'($signed(tb_));
        if (sb == 0) begin
            ez = 1'b1;
            eo = 1'b0;
            ec = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            q  = (sa * (64'sd1 <<< F)) / sb;
            ez = 1'b0;
            eo = (q > 64'sd2147483647) || (q < -64'sd2147483648);
            ec = q[W-1:0];
`ifdef FIXED_DIVIDE_SAT_EN
            if (eo) ec = (q > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        end
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_div(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int hold);
        logic [W-1:0] ec, held_c;
        logic ez, eo;
        int lat, exp_lat;
        model(ta, tb_, ec, ez, eo);
        exp_lat = (tb_ == '0) ? 1 : N + 1;
        check("in_ready_before", in_ready, 1);
        a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        while (!out_valid && lat < 200) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        $display("div a=%h b=%h -> c=%h dbz=%0d ovf=%0d lat=%0d", ta, tb_, c, div_by_zero, overflow, lat);
        check("latency", lat, exp_lat);
        check("c", c, ec);
        check("div_by_zero", div_by_zero, ez);
        check("overflow", overflow, eo);
        check("in_ready_done", in_ready, 0);
        held_c = c;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check("hold_c", c, held_c);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit seen_valid;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        do_div(32'h0000_3000, 32'h0000_2000, 0);
        do_div(32'hFFFF_D000, 32'h0000_2000, 0);
        do_div(32'h0000_1000, 32'h0000_0000, 0);
        do_div(32'hFFFF_F000, 32'h0000_0000, 0);
        do_div(32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_div(32'h8000_0000, 32'h0000_1000, 0);
        do_div(32'h8000_0000, 32'hFFFF_F000, 0);
        do_div(32'h8000_0000, 32'h0000_0001, 0);
        do_div(32'h0000_0000, 32'hFFFF_FFFF, 0);
        do_div(32'h1234_5678, 32'hFFFF_D000, 10);

        // Reset during CALC must abort without producing a result.
        a = 32'h0000_5000; b = 32'h0000_3000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_c", c, 0);
        check("midrst_dbz", div_by_zero, 0);
        check("midrst_ovf", overflow, 0);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_result", seen_valid, 0);
        do_div(32'h0000_5000, 32'h0000_3000, 0);

        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 15);
                2: rb = -$urandom_range(1, 1 << 14);
                default: rb = (k % 6 == 0) ? '0 : ($urandom >> $urandom_range(0, 24));
            endcase
            do_div(ra, rb, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fixed_divide_seq.md
FIXED_DIVIDE_SEQ -- requirements
Module: fixed_divide_seq

Interface
REQ-001 SHALL have parameter fractional_size, default 12, number of fractional bits of the signed Q-format operands and result.
REQ-002 SHALL have parameter operand_size, default 32, total two's-complement width W of a, b and c.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands a and b presented.
REQ-006 SHALL have port in_ready, output, 1, block idle and able to accept operands.
REQ-007 SHALL have port a, input, W, signed dividend.
REQ-008 SHALL have port b, input, W, signed divisor.
REQ-009 SHALL have port out_valid, output, 1, result c and flags valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port c, output, W, signed quotient (a / b) in the same Q format.
REQ-012 SHALL have port div_by_zero, output, 1, b was zero.
REQ-013 SHALL have port overflow, output, 1, the true quotient falls outside the signed W-bit range.

Function
REQ-014 SHALL compute c = trunc_toward_zero((a * 2^fractional_size) / b), the inverse of the fixed-point multiply.
REQ-015 SHALL implement an FSM with states IDLE, CALC and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 SHALL, in IDLE with in_valid=1 (accept edge), latch sign = a[W-1] xor b[W-1] and the W-bit unsigned magnitudes |a| and |b| (|-2^(W-1)| = 2^(W-1)), then enter CALC, or DONE if b == 0.
REQ-017 SHALL, in CALC, perform restoring radix-2 division producing one quotient bit per cycle for N = W + fractional_size cycles on the dividend |a| << fractional_size.
REQ-018 SHALL enter DONE after the Nth CALC cycle, so out_valid rises exactly N+1 cycles after the accept edge (45 with defaults).
REQ-019 SHALL, in DONE, apply the sign to the N-bit quotient magnitude Q and set overflow=1 when Q > 2^(W-1)-1 for a positive result, or Q > 2^(W-1) for a negative result.
REQ-020 SHALL hold c, div_by_zero and overflow stable while out_valid=1 and out_ready=0.
REQ-021 SHALL return from DONE to IDLE on the edge where out_ready=1; in_ready is 0 in that cycle, so no accept is possible in the DONE cycle.
REQ-022 SHALL, on b == 0, set div_by_zero=1 and overflow=0, and force c = 2^(W-1)-1 if a >= 0 or -2^(W-1) if a < 0, irrespective of the configuration.
REQ-023 SHALL ignore in_valid, a and b outside IDLE.

Reset
REQ-024 SHALL, on a clock edge with rst_n=0, enter IDLE and clear out_valid, c, div_by_zero, overflow and all datapath registers to 0.
REQ-025 SHALL abort any CALC or DONE in progress on reset without producing a result.
REQ-026 SHALL assert in_ready on the first edge after rst_n returns to 1.

Configuration
REQ-027 SHALL, with macro FIXED_DIVIDE_SAT_EN defined, clamp an overflowing result to 2^(W-1)-1 (positive) or -2^(W-1) (negative).
REQ-028 SHALL, without FIXED_DIVIDE_SAT_EN, output the low W bits of the signed quotient (wrap); overflow is flagged identically in both builds.

Verification
REQ-029 SHALL cover the positive case: a=0x00003000 (3.0), b=0x00002000 (2.0) -> c=0x00001800, flags 0, out_valid exactly 45 cycles after accept.
REQ-030 SHALL cover the mixed-sign case: a=0xFFFFD000 (-3.0), b=0x00002000 -> c=0xFFFFE800 (-1.5), flags 0.
REQ-031 SHALL cover divide by zero: a=0x00001000, b=0 -> c=0x7FFFFFFF, div_by_zero=1, out_valid 1 cycle after accept; a=0xFFFFF000, b=0 -> c=0x80000000.
REQ-032 SHALL cover overflow: a=0x7FFFFFFF, b=0x00000001 -> overflow=1, c=0x7FFFFFFF with FIXED_DIVIDE_SAT_EN and c=0xFFFFF000 without.
REQ-033 SHALL cover backpressure: hold out_ready=0 for 10 cycles -> c stable and in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-034 SHALL cover mid-operation reset: rst_n=0 on cycle 20 of CALC -> all outputs 0 and state IDLE on the next edge, and a fresh division afterwards is correct.
